// File: rtl/stepper_position_ctrl.sv
// Closed-count absolute stepper positioner: steps a 4-coil motor toward a signed
// half-step target at a fixed tick rate, with optional settle dwell and idle hold.
module stepper_position_ctrl #(
  parameter int POS_W        = 14,
  parameter int DIV_W        = 19,
  parameter int STEP_DIV     = 262144,
  parameter int SETTLE_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic signed [POS_W-1:0] target,
  input  logic                    half_step,
  input  logic                    hold_en,
  input  logic                    abort,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic signed [POS_W-1:0] position,
  output logic                    A1,
  output logic                    B1,
  output logic                    A2,
  output logic                    B2
);

  localparam int SET_W = $clog2(SETTLE_TICKS + 2);

  typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_e;

  state_e                  state_q;
  logic signed [POS_W-1:0] pos_q, tgt_q, pos_d;
  logic                    half_q;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [SET_W-1:0]        settle_q;
  logic                    done_q, err_q;

  logic [POS_W:0]          acc_delta;
  logic                    odd_reject, tick;
  logic signed [POS_W-1:0] step_mag;
  logic [3:0]              coils;

  // Extra sign bit keeps target - position exact over the full signed range.
  assign acc_delta  = {target[POS_W-1], target} - {pos_q[POS_W-1], pos_q};
  assign odd_reject = !half_step && acc_delta[0];

  assign tick     = (div_q == DIV_W'(STEP_DIV - 1));
  assign div_d    = tick ? '0 : div_q + DIV_W'(1);
  assign step_mag = half_q ? POS_W'(1) : POS_W'(2);
  assign pos_d    = (tgt_q > pos_q) ? pos_q + step_mag : pos_q - step_mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      tgt_q    <= '0;
      half_q   <= 1'b0;
      div_q    <= '0;
      settle_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load && !abort) begin
            if (odd_reject) begin
              err_q <= 1'b1;
            end else begin
              tgt_q    <= target;
              half_q   <= half_step;
              div_q    <= '0;
              settle_q <= '0;
              state_q  <= (acc_delta != '0) ? RUN : SETTLE;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            div_q   <= '0;
          end else begin
            div_q <= div_d;
            if (tick) begin
              pos_q <= pos_d;
              // Accepted full-step deltas are even, so equality is always hit exactly.
              if (pos_d == tgt_q) begin
                state_q  <= SETTLE;
                settle_q <= '0;
                div_q    <= '0;
              end
            end
          end
        end
        SETTLE: begin
          if (abort) begin
            state_q <= IDLE;
            div_q   <= '0;
          end else if (settle_q == SET_W'(SETTLE_TICKS)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            div_q <= div_d;
            if (tick) settle_q <= settle_q + SET_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  function automatic logic [3:0] phase_pattern(input logic [2:0] ph);
    case (ph)
      3'd0:    phase_pattern = 4'b1000;
      3'd1:    phase_pattern = 4'b1100;
      3'd2:    phase_pattern = 4'b0100;
      3'd3:    phase_pattern = 4'b0110;
      3'd4:    phase_pattern = 4'b0010;
      3'd5:    phase_pattern = 4'b0011;
      3'd6:    phase_pattern = 4'b0001;
      default: phase_pattern = 4'b1001;
    endcase
  endfunction

  assign coils    = (state_q != IDLE || hold_en) ? phase_pattern(pos_q[2:0]) : 4'b0000;
  assign {A1, B1, A2, B2} = coils;

  assign ready    = (state_q == IDLE);
  assign busy     = (state_q == RUN) || (state_q == SETTLE);
  assign done     = done_q;
  assign err      = err_q;
  assign position = pos_q;

endmodule

// File: tb/tb_stepper_position_ctrl.sv
// Bench for stepper_position_ctrl: a table of moves expands into per-cycle expected
// observations on a queue, popped and compared as the DUT runs.
module tb_stepper_position_ctrl;

  localparam int SD = 4;
  localparam int ST = 2;

  logic clk = 1'b0;
  logic reset_n, load, half_step, hold_en, abort;
  logic signed [13:0] target;
  logic ready, busy, done, err, A1, B1, A2, B2;
  logic signed [13:0] position;

  stepper_position_ctrl #(.POS_W(14), .DIV_W(19), .STEP_DIV(SD), .SETTLE_TICKS(ST)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .target(target), .half_step(half_step),
    .hold_en(hold_en), .abort(abort), .ready(ready), .busy(busy), .done(done), .err(err),
    .position(position), .A1(A1), .B1(B1), .A2(A2), .B2(B2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [13:0] tgt;
    logic               hs;
    logic               hold;
    logic               exp_err;
    int                 exp_n;
    logic signed [13:0] exp_final;
    int                 abort_at;
    int                 mid_at;
    logic signed [13:0] mid_tgt;
  } move_t;

  typedef struct packed {
    logic signed [13:0] pos;
    logic               busy;
    logic               ready;
    logic               done;
    logic               err;
    logic [3:0]         coils;
  } obs_t;

  obs_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [3:0] pat(input logic [2:0] ph);
    logic [3:0] t [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    return t[ph];
  endfunction

  function automatic obs_t model(input move_t m, input logic signed [13:0] p0, input int k);
    obs_t o;
    int step, dir, kdone, kk, nk;
    logic idle;
    o = '0;
    if (m.exp_err) begin
      o.pos = p0;
      idle  = 1'b1;
      o.err = (k == 0);
    end else begin
      step  = m.hs ? 1 : 2;
      dir   = (m.exp_final >= p0) ? 1 : -1;
      kdone = SD * m.exp_n + SD * ST + 1;
      kk    = (m.abort_at >= 0 && k >= m.abort_at) ? m.abort_at - 1 : k;
      nk    = kk / SD;
      if (nk > m.exp_n) nk = m.exp_n;
      o.pos  = p0 + 14'(dir * step * nk);
      idle   = (k >= kdone) || (m.abort_at >= 0 && k >= m.abort_at);
      o.done = (k == kdone) && (m.abort_at < 0);
    end
    o.busy  = !idle;
    o.ready = idle;
    o.coils = (!idle || m.hold) ? pat(o.pos[2:0]) : 4'b0000;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pos   = position;
    o.busy  = busy;
    o.ready = ready;
    o.done  = done;
    o.err   = err;
    o.coils = {A1, B1, A2, B2};
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  move_t tbl [6];

  initial begin
    obs_t got, exp;
    logic signed [13:0] p0;
    int kend, dones;

    tbl[0] = '{tgt:  14'sd5,   hs:0, hold:1, exp_err:1, exp_n:0,  exp_final:  14'sd0,  abort_at:-1, mid_at:-1, mid_tgt:14'sd0};
    tbl[1] = '{tgt:  14'sd3,   hs:1, hold:1, exp_err:0, exp_n:3,  exp_final:  14'sd3,  abort_at:-1, mid_at:-1, mid_tgt:14'sd0};
    tbl[2] = '{tgt: -14'sd1,   hs:0, hold:1, exp_err:0, exp_n:2,  exp_final: -14'sd1,  abort_at:-1, mid_at:-1, mid_tgt:14'sd0};
    tbl[3] = '{tgt:  14'sd100, hs:1, hold:1, exp_err:0, exp_n:11, exp_final:  14'sd10, abort_at:48, mid_at:-1, mid_tgt:14'sd0};
    tbl[4] = '{tgt:  14'sd10,  hs:0, hold:1, exp_err:0, exp_n:0,  exp_final:  14'sd10, abort_at:-1, mid_at:3,  mid_tgt:14'sd99};
    tbl[5] = '{tgt:  14'sd14,  hs:0, hold:0, exp_err:0, exp_n:2,  exp_final:  14'sd14, abort_at:-1, mid_at:2,  mid_tgt:-14'sd50};

    reset_n = 1'b0; load = 1'b0; half_step = 1'b0; hold_en = 1'b0; abort = 1'b0; target = '0;
    #12;
    chk("reset_pos",   32'(position), 32'(0));
    chk("reset_coils", 32'({A1, B1, A2, B2}), 32'(0));
    chk("reset_flags", 32'({ready, busy, done, err}), 32'(4'b1000));
    @(negedge clk);
    reset_n = 1'b1;
    hold_en = 1'b1;
    #1;
    chk("hold_coils", 32'({A1, B1, A2, B2}), 32'(4'b1000));

    p0 = '0;
    for (int i = 0; i < 6; i++) begin
      kend = tbl[i].exp_err ? 1 :
             (tbl[i].abort_at >= 0) ? tbl[i].abort_at : SD * tbl[i].exp_n + SD * ST + 2;
      for (int k = 0; k <= kend; k++) sb.push_back(model(tbl[i], p0, k));
      @(negedge clk);
      target = tbl[i].tgt; half_step = tbl[i].hs; hold_en = tbl[i].hold; abort = 1'b0; load = 1'b1;
      for (int k = 0; k <= kend; k++) begin
        @(posedge clk);
        @(negedge clk);
        got = sample();
        exp = sb.pop_front();
        chk($sformatf("move%0d_k%0d", i, k), 32'(got), 32'(exp));
        if (k == 0) load = 1'b0;
        if (k == tbl[i].mid_at - 1) begin load = 1'b1; target = tbl[i].mid_tgt; half_step = 1'b1; end
        if (k == tbl[i].mid_at) load = 1'b0;
        if (tbl[i].abort_at >= 0 && k == tbl[i].abort_at - 1) abort = 1'b1;
        if (k == tbl[i].abort_at) abort = 1'b0;
      end
      p0 = tbl[i].exp_final;
    end

    // Load together with abort in IDLE: ignored silently.
    target = 14'sd20; half_step = 1'b1; load = 1'b1; abort = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("ldabort_flags", 32'({ready, busy, err}), 32'(3'b100));
    load = 1'b0; abort = 1'b0;
    repeat (5) @(negedge clk);
    chk("ldabort_pos", 32'(position), 32'(14));

    // Abort during SETTLE: back to IDLE, no done ever appears.
    target = 14'sd14; load = 1'b1;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
    chk("settle_busy", 32'(busy), 32'(1));
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("settle_abort", 32'({ready, busy, position}), 32'({2'b10, 14'sd14}));
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("settle_nodone", 32'(dones), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
